// File: rtl/fifo_pkg.sv
// Shared sizing for the 32x8 FIFO storage block and its pointer/flag controller.
package fifo_pkg;

    localparam int FIFO_PTR_W    = 5;
    localparam int FIFO_DATA_W   = 8;
    localparam int FIFO_DEPTH    = 2 ** FIFO_PTR_W;
    localparam int FIFO_AF_LEVEL = 28;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: MSB toggles each time the address bits roll over.
// Synchronous clear has priority over increment.
module fifo_ptr #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the 32x8 FIFO storage block.
// Optional sticky overflow/underflow flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W   = FIFO_DATA_W,
    parameter int PTR_W    = FIFO_PTR_W,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    input  logic              i_err_clr,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic [PTR_W:0]    o_count,
    output logic              o_rd_valid,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_mem_en_write,
    output logic [PTR_W-1:0]  o_mem_ptr_in,
    output logic [DATA_W-1:0] o_mem_data_in,
    output logic              o_mem_en_read,
    output logic [PTR_W-1:0]  o_mem_ptr_out
);

    logic [PTR_W:0] w_wr_ptr;
    logic [PTR_W:0] w_rd_ptr;
    logic [PTR_W:0] w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic           r_rd_valid;

    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[PTR_W-1:0] == w_rd_ptr[PTR_W-1:0]) &&
                     (w_wr_ptr[PTR_W] != w_rd_ptr[PTR_W]);
    assign w_count = w_wr_ptr - w_rd_ptr;

    // Gating with reset keeps storage quiet while reset is held, even if requests are up.
    assign w_push_ok = i_rst_n & i_push & ~w_full  & ~i_flush;
    assign w_pop_ok  = i_rst_n & i_pop  & ~w_empty & ~i_flush;

    fifo_ptr #(.W(PTR_W + 1)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_inc   (w_push_ok),
        .o_ptr   (w_wr_ptr)
    );

    fifo_ptr #(.W(PTR_W + 1)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_inc   (w_pop_ok),
        .o_ptr   (w_rd_ptr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
        end
    end

    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_count       = w_count;
    assign o_almost_full = (w_count >= (PTR_W + 1)'(AF_LEVEL));
    assign o_rd_valid    = r_rd_valid;

    // Address and data lines are held at zero unless the matching strobe is active.
    assign o_mem_en_write = w_push_ok;
    assign o_mem_ptr_in   = w_push_ok ? w_wr_ptr[PTR_W-1:0] : '0;
    assign o_mem_data_in  = w_push_ok ? i_wdata : '0;
    assign o_mem_en_read  = w_pop_ok;
    assign o_mem_ptr_out  = w_pop_ok ? w_rd_ptr[PTR_W-1:0] : '0;

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A rejected request in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (i_pop && w_empty) begin
                r_underflow <= 1'b1;
            end else if (i_err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = i_err_clr;
    assign o_overflow       = 1'b0;
    assign o_underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model plus a behavioural 32x8 storage array.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       full, empty, almost_full, rd_valid, overflow, underflow;
    logic [5:0] count;
    logic       mem_en_write, mem_en_read;
    logic [4:0] mem_ptr_in, mem_ptr_out;
    logic [7:0] mem_data_in;

    fifo_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_push         (push),
        .i_wdata        (wdata),
        .i_pop          (pop),
        .i_err_clr      (err_clr),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_count        (count),
        .o_rd_valid     (rd_valid),
        .o_overflow     (overflow),
        .o_underflow    (underflow),
        .o_mem_en_write (mem_en_write),
        .o_mem_ptr_in   (mem_ptr_in),
        .o_mem_data_in  (mem_data_in),
        .o_mem_en_read  (mem_en_read),
        .o_mem_ptr_out  (mem_ptr_out)
    );

    always #5 clk = ~clk;

    // Storage array as the controller sees it.
    logic [7:0] mem [32];
    logic [7:0] mem_dout;

    always @(posedge clk) begin
        if (mem_en_write) mem[mem_ptr_in] <= mem_data_in;
        if (mem_en_read)  mem_dout <= mem[mem_ptr_out];
    end

    // Reference model: contents in order, accepted push/pop totals, expected read word.
    logic [7:0] q [$];
    int         wr_n, rd_n;
    bit         m_rv;
    logic [7:0] m_rdata;
    bit         m_ovf, m_unf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_n  = 0;
        rd_n  = 0;
        m_rv  = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check_regs();
        check("count", 32'(count), 32'(q.size()));
        check("full", 32'(full), 32'(q.size() == 32));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("almost_full", 32'(almost_full), 32'(q.size() >= 28));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        if (m_rv) check("rd_data", 32'(mem_dout), 32'(m_rdata));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input bit p, input logic [7:0] wd, input bit r, input bit fl, input bit ec);
        bit was_full, was_empty, push_ok, pop_ok;
        @(negedge clk);
        check_regs();
        push    = p;
        wdata   = wd;
        pop     = r;
        flush   = fl;
        err_clr = ec;
        #1;
        was_full  = (q.size() == 32);
        was_empty = (q.size() == 0);
        push_ok   = p && !was_full && !fl;
        pop_ok    = r && !was_empty && !fl;
        check("mem_en_write", 32'(mem_en_write), 32'(push_ok));
        check("mem_ptr_in", 32'(mem_ptr_in), push_ok ? 32'(wr_n % 32) : 32'd0);
        check("mem_data_in", 32'(mem_data_in), push_ok ? 32'(wd) : 32'd0);
        check("mem_en_read", 32'(mem_en_read), 32'(pop_ok));
        check("mem_ptr_out", 32'(mem_ptr_out), pop_ok ? 32'(rd_n % 32) : 32'd0);
        if (fl) begin
            q.delete();
            wr_n = 0;
            rd_n = 0;
            m_rv = 0;
        end else begin
            if (pop_ok) begin
                m_rdata = q.pop_front();
                rd_n++;
            end
            if (push_ok) begin
                q.push_back(wd);
                wr_n++;
            end
            m_rv = pop_ok;
        end
`ifdef FIFO_CTRL_ERR_EN
        if (fl) begin
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (p && was_full) m_ovf = 1;
            else if (ec)       m_ovf = 0;
            if (r && was_empty) m_unf = 1;
            else if (ec)        m_unf = 0;
        end
`endif
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic reset_mid_burst();
        @(negedge clk);
        push  = 1;
        pop   = 1;
        wdata = 8'hA5;
        flush = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_en_write", 32'(mem_en_write), 32'd0);
        check("rst_en_read", 32'(mem_en_read), 32'd0);
        check("rst_ptr_in", 32'(mem_ptr_in), 32'd0);
        check("rst_data_in", 32'(mem_data_in), 32'd0);
        @(negedge clk);
        check("rst_hold_en_write", 32'(mem_en_write), 32'd0);
        push = 0;
        pop  = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_regs();
        check("reset_en_write", 32'(mem_en_write), 32'd0);
        check("reset_en_read", 32'(mem_en_read), 32'd0);
        rst_n = 1;

        // Two words through.
        step(1, 8'h0A, 0, 0, 0);
        step(1, 8'h1B, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        idle();

        // Fill to full, then one rejected push.
        for (int i = 0; i < 32; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        idle();
        // Push+pop at full: only the pop goes through.
        step(1, 8'h77, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        while (q.size() > 0) step(0, 8'h00, 1, 0, 0);
        // Pop on empty, then clear the error.
        step(0, 8'h00, 1, 0, 0);
        idle();
        step(0, 8'h00, 0, 0, 1);
        idle();

        // Simultaneous push+pop at count 5, then at empty.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        while (q.size() > 0) step(0, 8'h00, 1, 0, 0);
        step(1, 8'h66, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);

        // Pairs crossing the 31->0 address boundary.
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1, 0, 0);

        // Flush at count 10 while pushing.
        while (q.size() < 10) step(1, 8'($urandom), 0, 0, 0);
        while (q.size() > 10) step(0, 8'h00, 1, 0, 0);
        step(1, 8'h99, 1, 1, 0);
        idle();

        // Randomized traffic with shifting bias so both full and empty are reached.
        for (int blk = 0; blk < 8; blk++) begin
            int push_pct;
            push_pct = (blk % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 60; i++) begin
                step($urandom_range(99) < push_pct, 8'($urandom),
                     $urandom_range(99) < (100 - push_pct),
                     $urandom_range(99) < 2, $urandom_range(99) < 10);
            end
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), i > 2, 0, 0);
        reset_mid_burst();
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        idle();

        @(negedge clk);
        check_regs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
